// File: rtl/imm_pkg.sv
// Shared opcode constants, format codes and decode metadata for the immediate generator.
package imm_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned FMT_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_IMM32  = 7'b0011011;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

    localparam logic [FMT_W-1:0] FMT_I    = 3'd0;
    localparam logic [FMT_W-1:0] FMT_S    = 3'd1;
    localparam logic [FMT_W-1:0] FMT_B    = 3'd2;
    localparam logic [FMT_W-1:0] FMT_U    = 3'd3;
    localparam logic [FMT_W-1:0] FMT_J    = 3'd4;
    localparam logic [FMT_W-1:0] FMT_NONE = 3'd7;

    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic             illegal;
    } dec_meta_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: instruction word -> sign-extended immediate and format.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]      inst,
    output logic [XLEN-1:0]  imm,
    output logic [FMT_W-1:0] fmt,
    output logic             illegal
);

    logic signed [31:0] imm32;

    always_comb begin
        fmt   = FMT_NONE;
        imm32 = '0;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: fmt = FMT_I;
            OP_IMM32:                            fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            OP_STORE:                            fmt = FMT_S;
            OP_BRANCH:                           fmt = FMT_B;
            OP_LUI, OP_AUIPC:                    fmt = FMT_U;
            OP_JAL:                              fmt = FMT_J;
            default:                             fmt = FMT_NONE;
        endcase
        // Every format is built as a 32-bit signed value, then widened to XLEN.
        case (fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_J:   imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm     = XLEN'(imm32);
    assign illegal = (fmt == FMT_NONE);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with PC-relative adder, presented through a two-entry skid buffer.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic [FMT_W-1:0] out_fmt,
    output logic             out_illegal,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc
);

    localparam dec_meta_t META_RST = '{fmt: FMT_NONE, illegal: 1'b0};

    logic [XLEN-1:0]  dec_imm;
    logic [FMT_W-1:0] dec_fmt;
    logic             dec_illegal;
    logic [XLEN-1:0]  in_target;
    dec_meta_t        in_meta;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_target = in_pc + dec_imm;
    assign in_meta   = '{fmt: dec_fmt, illegal: dec_illegal};

    logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [XLEN-1:0]  m_imm_q, m_imm_d, s_imm_q, s_imm_d;
    logic [XLEN-1:0]  m_target_q, m_target_d, s_target_q, s_target_d;
    logic [XLEN-1:0]  m_pc_q, m_pc_d, s_pc_q, s_pc_d;
    logic [31:0]      m_inst_q, m_inst_d, s_inst_q, s_inst_d;
    dec_meta_t        m_meta_q, m_meta_d, s_meta_q, s_meta_d;
    logic             accept, fire;

    assign in_ready = reset & ~s_valid_q;

    // Skid control: main refills from skid first (FIFO order), else from the input.
    always_comb begin
        m_valid_d  = m_valid_q;
        m_imm_d    = m_imm_q;
        m_target_d = m_target_q;
        m_pc_d     = m_pc_q;
        m_inst_d   = m_inst_q;
        m_meta_d   = m_meta_q;
        s_valid_d  = s_valid_q;
        s_imm_d    = s_imm_q;
        s_target_d = s_target_q;
        s_pc_d     = s_pc_q;
        s_inst_d   = s_inst_q;
        s_meta_d   = s_meta_q;
        accept     = in_valid & in_ready;
        fire       = m_valid_q & out_ready;

        if (!m_valid_q || fire) begin
            if (s_valid_q) begin
                m_imm_d    = s_imm_q;
                m_target_d = s_target_q;
                m_pc_d     = s_pc_q;
                m_inst_d   = s_inst_q;
                m_meta_d   = s_meta_q;
            end else if (accept) begin
                m_imm_d    = dec_imm;
                m_target_d = in_target;
                m_pc_d     = in_pc;
                m_inst_d   = in_inst;
                m_meta_d   = in_meta;
            end
        end else if (accept) begin
            s_imm_d    = dec_imm;
            s_target_d = in_target;
            s_pc_d     = in_pc;
            s_inst_d   = in_inst;
            s_meta_d   = in_meta;
        end

        m_valid_d = s_valid_q | accept | (m_valid_q & ~fire);
        s_valid_d = s_valid_q ? ~fire : (accept & m_valid_q & ~fire);

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_valid_q  <= 1'b0;
            m_imm_q    <= '0;
            m_target_q <= '0;
            m_pc_q     <= '0;
            m_inst_q   <= '0;
            m_meta_q   <= META_RST;
            s_valid_q  <= 1'b0;
            s_imm_q    <= '0;
            s_target_q <= '0;
            s_pc_q     <= '0;
            s_inst_q   <= '0;
            s_meta_q   <= META_RST;
        end else begin
            m_valid_q  <= m_valid_d;
            m_imm_q    <= m_imm_d;
            m_target_q <= m_target_d;
            m_pc_q     <= m_pc_d;
            m_inst_q   <= m_inst_d;
            m_meta_q   <= m_meta_d;
            s_valid_q  <= s_valid_d;
            s_imm_q    <= s_imm_d;
            s_target_q <= s_target_d;
            s_pc_q     <= s_pc_d;
            s_inst_q   <= s_inst_d;
            s_meta_q   <= s_meta_d;
        end
    end

    assign out_valid   = m_valid_q;
    assign out_imm     = m_imm_q;
    assign out_target  = m_target_q;
    assign out_fmt     = m_meta_q.fmt;
    assign out_illegal = m_meta_q.illegal;
    assign out_inst    = m_inst_q;
    assign out_pc      = m_pc_q;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the ID stage of the pipelined RV core. It decodes every RISC-V immediate format (I, S, B, U, J) and sign-extends to `XLEN`. It also computes the PC-relative target `pc + imm` and flags opcodes that carry no immediate. Results are presented through a registered valid/ready stage with a two-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`; ID/EX stall and flush map directly onto it.

## Interface
- `XLEN`, 64, datapath width; legal values 32 or 64.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clk`.
- `flush`  in  1  synchronous pipeline flush; drops all held and incoming entries.
- `in_valid`  in  1  `in_inst`/`in_pc` valid.
- `in_ready`  out  1  block can accept this cycle.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  XLEN  PC of `in_inst`.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  consumer accepts this cycle.
- `out_imm`  out  XLEN  sign-extended immediate.
- `out_target`  out  XLEN  `out_pc + out_imm`, modulo 2^XLEN.
- `out_fmt`  out  3  format code (package constants).
- `out_illegal`  out  1  opcode has no immediate, or is not legal for `XLEN`.
- `out_inst`  out  32  forwarded instruction.
- `out_pc`  out  XLEN  forwarded PC.

## Operation
- Decode uses the full 7-bit opcode:
  - I: 0000011, 0010011, 1100111, 1110011, and 0011011 (XLEN=64 only).
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- Immediate assembly:
  - I = `inst[31:20]`.
  - S = `{inst[31:25], inst[11:7]}`.
  - B = `{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`.
  - U = `{inst[31:12], 12'b0}`.
  - J = `{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}`.
  - All formats are sign-extended from their MSB to `XLEN`.
- Shift immediates are not special-cased; the consumer masks the shamt.
- Any other opcode, or 0011011 when XLEN=32, gives `out_imm`=0, `out_fmt`=FMT_NONE (3'd7), `out_illegal`=1, `out_target`=`out_pc`.
- `out_target` is computed for every format; its meaning is defined only for B, J and AUIPC.
- Skid buffer state is the main entry (`m_valid`) and the skid entry (`s_valid`):
  - EMPTY (m=0, s=0): accept into main.
  - ONE (m=1, s=0):
    - Simultaneous accept and out-fire: main is replaced.
    - Accept without fire: the new entry goes to skid, giving FULL.
    - Fire only: go to EMPTY.
  - FULL (m=1, s=1): `in_ready`=0. On out-fire, skid moves to main, giving ONE.
- `in_ready` = `reset & ~s_valid`, a registered-state function only.
- Ordering is strict FIFO. No entry is lost or duplicated.

## Timing
- Latency: 1 cycle. An input accepted at edge N is visible on the outputs after edge N when main is empty.
- Throughput: 1 per cycle while `out_ready`=1.
- Reset (`reset`=0 at an edge):
  - Outputs after that edge: `out_valid`=0, `out_imm`=0, `out_target`=0, `out_fmt`=FMT_NONE, `out_illegal`=0, `out_inst`=0, `out_pc`=0.
  - `in_ready`=0 for as long as `reset`=0.
  - Reset mid-stream discards both entries.
- Flush: at the flushing edge both entries are cleared and an incoming `in_valid` is dropped. After that edge, `out_valid`=0 and `in_ready`=1. Flush has priority over accept and fire.
- Output payload holds stable while `out_valid`=1 and `out_ready`=0.
- `out_ready` asserted with `out_valid`=0 has no effect.

## Structure
- Package `imm_pkg`:
  - Opcode constants (OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL).
  - 3-bit format codes: FMT_I=0, FMT_S=1, FMT_B=2, FMT_U=3, FMT_J=4, FMT_NONE=7.
- Sub-module `imm_decode`, parametrised by `XLEN`: purely combinational, `inst` -> {imm, fmt, illegal}. It is instantiated once at the input, so the registered state holds decoded values.
- `imm_gen_pipe` contains the adder and the skid-buffer control.

## Test plan
- B-type: `in_inst`=0xFE000EE3 (beq x0,x0,-4), `in_pc`=0x1000, XLEN=64 -> `out_imm`=0xFFFF_FFFF_FFFF_FFFC, `out_target`=0xFFC, FMT_B, `out_illegal`=0, one cycle later.
- U/J: 0x800000B7 -> `out_imm`=0xFFFF_FFFF_8000_0000, FMT_U. 0x0010006F with pc=0 -> `out_imm`=0x800, `out_target`=0x800, FMT_J.
- Backpressure: `in_valid`=1 with 5 sequential instructions, `out_ready`=0 for 3 cycles -> `in_ready` falls after 2 accepts. After release, all 5 emerge in order, none duplicated, payload stable while stalled.
- Flush with FULL buffer plus `in_valid`=1 -> next cycle `out_valid`=0, `in_ready`=1, none of the three entries ever emerges.
- Illegal: 0x0000007F -> `out_illegal`=1, `out_imm`=0, FMT_NONE, `out_target`=pc. With XLEN=32, 0x0000001B -> `out_illegal`=1.
- Reset low for 1 cycle mid-stream with both entries valid -> all outputs at reset values, `in_ready`=0 during reset and 1 on the following cycle.
